// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, PC-1/PC-2 tables,
// shift schedule, FSM state encoding and 28-bit rotate helpers.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;
    localparam int ROUNDS = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ks_state_e;

    // DES bit numbers (1 = MSB), PC-1 output bit 1 first.
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // C/D bit numbers (1 = MSB of C), PC-2 output bit 1 first.
    localparam int PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Entry i is the shift applied before round key K(i+1).
    localparam int SHIFT [ROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    function automatic logic [HALF_W-1:0] rotl28(
        input logic [HALF_W-1:0] x,
        input logic              two
    );
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(
        input logic [HALF_W-1:0] x,
        input logic              two
    );
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 selection: 56-bit C||D in, 48-bit round subkey out.
// Ports: cd_i (C in [55:28], D in [27:0]), subkey_o (bit 47 = PC-2 bit 1).
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_i,
    output logic [SK_W-1:0] subkey_o
);

    for (genvar i = 0; i < SK_W; i++) begin : g_sel
        assign subkey_o[SK_W-1-i] = cd_i[CD_W-PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads a key, emits 16 subkeys over a
// valid/ready handshake (K1..K16 encrypt, K16..K1 decrypt).
// Ports: clk, rst (sync, active high), start/key/decrypt load a schedule;
// subkey/subkey_valid/subkey_ready handshake; round, busy, done status;
// parity_err is live only when DES_KS_PARITY_CHECK_EN is defined.
module des_key_schedule
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic             decrypt,
    output logic [SK_W-1:0]  subkey,
    output logic             subkey_valid,
    input  logic             subkey_ready,
    output logic [3:0]       round,
    output logic             busy,
    output logic             done,
    output logic             parity_err
);

    ks_state_e         state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              dec_q, dec_d;
    logic              done_q, done_d;

    logic [CD_W-1:0]   pc1_key;
    logic [HALF_W-1:0] c_ld, d_ld;
    logic [3:0]        sidx;
    logic              two;

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_key[CD_W-1-i] = key[KEY_W-PC1[i]];
    end

    assign c_ld = pc1_key[CD_W-1:HALF_W];
    assign d_ld = pc1_key[HALF_W-1:0];

    // Shift for the key that follows the one now presented.
    assign sidx = dec_q ? (4'd15 - round_q) : (round_q + 4'd1);
    assign two  = (SHIFT[sidx] == 2);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dec_d   = decrypt;
                    round_d = 4'd0;
                    // Total shift is 28, so unrotated PC-1 is C16/D16.
                    c_d = decrypt ? c_ld : rotl28(c_ld, 1'b0);
                    d_d = decrypt ? d_ld : rotl28(d_ld, 1'b0);
                end
            end
            ST_RUN: begin
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        c_d = dec_q ? rotr28(c_q, two)
                                    : rotl28(c_q, two);
                        d_d = dec_q ? rotr28(d_q, two)
                                    : rotl28(d_q, two);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey)
    );

    assign subkey_valid = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign round        = round_q;
    assign done         = done_q;

`ifdef DES_KS_PARITY_CHECK_EN
    logic       par_q, par_d;
    logic [7:0] byte_bad;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_bad[b] = ~^key[8*b +: 8];
    end

    always_comb begin
        par_d = par_q;
        if (state_q == ST_IDLE && start) begin
            par_d = |byte_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end

    assign parity_err = par_q;
`else
    // Parity bits are dropped by PC-1 and have no other consumer here.
    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};
    assign parity_err = 1'b0;
`endif

endmodule
